// File: rtl/audio_sample_feeder.sv
// Sample FIFO feeding the PWM stage: prebuffers in PRIME, releases one sample
// per SAMPLE_DIV clocks in PLAY, and holds mid-scale while idle.
module audio_sample_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SAMPLE_DIV = 2268,
    parameter logic [4:0]  IDLE_LEVEL = 5'd16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [4:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [4:0]               pwm_ref,
    output logic                     sample_tick,
    output logic                     underrun,
    input  logic                     clear_underrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0] HALF_LVL = LW'(DEPTH / 2);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [4:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_full;
    logic            r_empty;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_pwm;
    logic            r_tick;
    logic            r_underrun;

    logic            w_due;
    logic            w_pop;
    logic            w_underrun_evt;
    logic            w_wr;
    logic [LW-1:0]   w_level_nxt;
    logic [4:0]      w_pwm_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // enable=0 overrides everything, then flush, then normal FSM progress.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else if (flush) begin
            w_state_nxt = S_PRIME;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_PRIME;
                S_PRIME: if (r_level >= HALF_LVL) w_state_nxt = S_PLAY;
                S_PLAY:  if (w_due && r_empty) w_state_nxt = S_PRIME;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_due          = (r_state == S_PLAY) && (r_cnt == DIV_LAST) && enable && !flush;
        w_pop          = w_due && !r_empty;
        w_underrun_evt = w_due && r_empty;
        w_wr           = wr_en && !r_full && !flush;

        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_wr && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_wr && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end

        w_pwm_nxt = r_pwm;
        if (w_state_nxt == S_IDLE) begin
            w_pwm_nxt = IDLE_LEVEL;
        end else if (w_pop) begin
            w_pwm_nxt = r_mem[r_rd_ptr];
        end

        w_cnt_nxt = '0;
        if ((r_state == S_PLAY) && (w_state_nxt == S_PLAY) && (r_cnt != DIV_LAST)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_cnt      <= '0;
            r_pwm      <= IDLE_LEVEL;
            r_tick     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == FULL_LVL);
            r_empty <= (w_level_nxt == '0);
            r_cnt   <= w_cnt_nxt;
            r_pwm   <= w_pwm_nxt;
            r_tick  <= w_pop;
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign full        = r_full;
    assign empty       = r_empty;
    assign level       = r_level;
    assign pwm_ref     = r_pwm;
    assign sample_tick = r_tick;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed vector bench for audio_sample_feeder at DEPTH=4, SAMPLE_DIV=4.
module tb_audio_sample_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flush;
    logic       wr_en;
    logic [4:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic [4:0] pwm_ref;
    logic       sample_tick;
    logic       underrun;
    logic       clear_underrun;

    int total = 0;
    int bad   = 0;

    audio_sample_feeder #(
        .DEPTH      (4),
        .SAMPLE_DIV (4),
        .IDLE_LEVEL (5'd16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .empty          (empty),
        .level          (level),
        .pwm_ref        (pwm_ref),
        .sample_tick    (sample_tick),
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       fl;
        logic       we;
        logic [4:0] wd;
        logic       clr;
        logic       full;
        logic       empty;
        logic [2:0] lvl;
        logic [4:0] pwm;
        logic       tick;
        logic       ur;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic en, input logic fl, input logic we,
                       input logic [4:0] wd, input logic clr, input logic e_full,
                       input logic e_empty, input logic [2:0] e_lvl, input logic [4:0] e_pwm,
                       input logic e_tick, input logic e_ur);
        vec_t v;
        v.en = en; v.fl = fl; v.we = we; v.wd = wd; v.clr = clr;
        v.full = e_full; v.empty = e_empty; v.lvl = e_lvl; v.pwm = e_pwm;
        v.tick = e_tick; v.ur = e_ur;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    function automatic logic [11:0] pack_out();
        return {full, empty, level, pwm_ref, sample_tick, underrun};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = pack_out();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {full,empty,lvl,pwm,tick,ur}=%b_%b_%0d_%0d_%b_%b required %b_%b_%0d_%0d_%b_%b",
                     name, act[11], act[10], act[9:7], act[6:2], act[1], act[0],
                     exp[11], exp[10], exp[9:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic en, input logic fl, input logic we,
                         input logic [4:0] wd, input logic clr);
        @(negedge clk);
        enable = en; flush = fl; wr_en = we; wr_data = wd; clear_underrun = clr;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; flush = 1'b0; wr_en = 1'b0;
        wr_data = '0; clear_underrun = 1'b0;

        // prebuffer, two pops, then underrun on the third due pop
        add(1, 1,0,1, 3,0,  0,0,1,16,0,0);
        add(1, 1,0,1, 7,0,  0,0,2,16,0,0);
        add(4, 1,0,0, 0,0,  0,0,2,16,0,0);
        add(1, 1,0,0, 0,0,  0,0,1, 3,1,0);
        add(3, 1,0,0, 0,0,  0,0,1, 3,0,0);
        add(1, 1,0,0, 0,0,  0,1,0, 7,1,0);
        add(3, 1,0,0, 0,0,  0,1,0, 7,0,0);
        add(1, 1,0,0, 0,0,  0,1,0, 7,0,1);
        add(1, 1,0,1, 9,1,  0,0,1, 7,0,0);
        add(1, 1,0,0, 0,0,  0,0,1, 7,0,0);
        // flush to IDLE, fill past full while disabled
        add(1, 0,1,0, 0,0,  0,1,0,16,0,0);
        add(1, 0,0,1, 1,0,  0,0,1,16,0,0);
        add(1, 0,0,1, 2,0,  0,0,2,16,0,0);
        add(1, 0,0,1, 3,0,  0,0,3,16,0,0);
        add(1, 0,0,1, 4,0,  1,0,4,16,0,0);
        add(1, 0,0,1, 5,0,  1,0,4,16,0,0);
        // play two samples, disable mid-period, re-enable
        add(5, 1,0,0, 0,0,  1,0,4,16,0,0);
        add(1, 1,0,0, 0,0,  0,0,3, 1,1,0);
        add(3, 1,0,0, 0,0,  0,0,3, 1,0,0);
        add(1, 1,0,0, 0,0,  0,0,2, 2,1,0);
        add(1, 1,0,0, 0,0,  0,0,2, 2,0,0);
        add(1, 0,0,0, 0,0,  0,0,2,16,0,0);
        add(5, 1,0,0, 0,0,  0,0,2,16,0,0);
        add(1, 1,0,0, 0,0,  0,0,1, 3,1,0);
        add(3, 1,0,0, 0,0,  0,0,1, 3,0,0);
        // flush (with a write) on the pop-due edge
        add(1, 1,1,1,11,0,  0,1,0, 3,0,0);
        add(1, 1,0,0, 0,0,  0,1,0, 3,0,0);
        // refill, drain, underrun with clear in the same cycle
        add(1, 1,0,1,12,0,  0,0,1, 3,0,0);
        add(1, 1,0,1,13,0,  0,0,2, 3,0,0);
        add(4, 1,0,0, 0,0,  0,0,2, 3,0,0);
        add(1, 1,0,0, 0,0,  0,0,1,12,1,0);
        add(3, 1,0,0, 0,0,  0,0,1,12,0,0);
        add(1, 1,0,0, 0,0,  0,1,0,13,1,0);
        add(3, 1,0,0, 0,0,  0,1,0,13,0,0);
        add(1, 1,0,0, 0,1,  0,1,0,13,0,1);
        add(1, 1,0,0, 0,0,  0,1,0,13,0,1);

        repeat (3) @(posedge clk);
        #1 check("in_reset", {1'b0,1'b1,3'd0,5'd16,1'b0,1'b0});
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1 check("after_reset", {1'b0,1'b1,3'd0,5'd16,1'b0,1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].fl, vecs[i].we, vecs[i].wd, vecs[i].clr);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {vecs[i].full, vecs[i].empty, vecs[i].lvl,
                                           vecs[i].pwm, vecs[i].tick, vecs[i].ur});
        end

        // async reset mid-period while playing with underrun still set
        drive(1,0,1,21,0);
        drive(1,0,1,22,0);
        drive(1,0,0,0,0);
        drive(1,0,0,0,0);
        drive(1,0,0,0,0);
        @(posedge clk); #1 check("pre_async_reset", {1'b0,1'b0,3'd2,5'd13,1'b0,1'b1});
        @(posedge clk); #3 reset = 1'b0;
        #1 check("async_reset", {1'b0,1'b1,3'd0,5'd16,1'b0,1'b0});
        @(posedge clk); #1 check("reset_held", {1'b0,1'b1,3'd0,5'd16,1'b0,1'b0});
        @(negedge clk) begin reset = 1'b1; enable = 1'b0; end
        @(posedge clk); #1 check("post_release", {1'b0,1'b1,3'd0,5'd16,1'b0,1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_feeder.md
Name: audio_sample_feeder

Overview:
Upstream stage of the audio PWM output. Buffers 5-bit audio samples written by the sample source in a small FIFO and releases one sample per sample period onto pwm_ref. The PWM stage consumes pwm_ref as its duty reference. The block handles prebuffering, underrun detection and idle mid-scale output.

Parameters:
DEPTH, 16, FIFO depth in samples; power of two, minimum 4.
SAMPLE_DIV, 2268, clk cycles per sample period (100 MHz / 44.1 kHz); minimum 2.
IDLE_LEVEL, 16, pwm_ref value while not playing (5-bit mid-scale).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  play request; level-sensitive
flush  input  1  synchronous FIFO clear, one-cycle pulse
wr_en  input  1  sample write strobe
wr_data  input  5  sample to write
full  output  1  FIFO holds DEPTH samples
empty  output  1  FIFO holds 0 samples
level  output  log2(DEPTH)+1  current FIFO occupancy
pwm_ref  output  5  duty reference to the PWM stage, registered
sample_tick  output  1  one-cycle pulse on each sample pop
underrun  output  1  sticky: a pop was due while FIFO empty
clear_underrun  input  1  clears underrun

Behaviour:
- Reset (reset=0, asynchronous) drives the following values:
  - pwm_ref=IDLE_LEVEL, full=0, empty=1, level=0, sample_tick=0, underrun=0.
  - State IDLE; read/write pointers and divider count = 0.
- FIFO:
  - A write is accepted when wr_en=1 and full=0 at that edge. A write while full is dropped and level is unchanged.
  - full and empty are registered functions of level. full applies pre-edge, so a write is rejected when full even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - A sample written at edge N is visible to a pop no earlier than edge N+1.
- flush=1:
  - Pointers and level go to 0 at the next edge; any same-cycle write is discarded.
  - The state goes to PRIME if enable=1, else IDLE.
  - pwm_ref holds its value unless the state becomes IDLE.
- Divider counts 0..SAMPLE_DIV-1 only in PLAY. It is held at 0 in every other state.
- Pop: at the edge where the count equals SAMPLE_DIV-1 in PLAY:
  - If not empty, the FIFO head is registered into pwm_ref at that edge and sample_tick=1 for that one cycle.
  - Latency from terminal count to a new pwm_ref is 1 edge.
  - The same-cycle rule applies: a word written at that edge is not popped.
- State machine:
  - IDLE: pwm_ref=IDLE_LEVEL. Moves to PRIME when enable=1.
  - PRIME: divider held, pwm_ref holds its last value. Moves to PLAY when level >= DEPTH/2. Moves to IDLE when enable=0.
  - PLAY: pops as above.
    - enable=0 → IDLE; pwm_ref=IDLE_LEVEL on the following edge; FIFO contents are retained.
    - Pop due with empty=1 → underrun set, pwm_ref held, no sample_tick, state → PRIME.
- enable=0 takes priority over all other transitions except reset. flush takes priority over a pop due in the same cycle.
- underrun:
  - Set by an underrun event and cleared by clear_underrun.
  - Set wins when both occur in the same cycle.
  - Not cleared by flush or by leaving PLAY.
- pwm_ref changes at most once per SAMPLE_DIV cycles in PLAY, so a slower-clocked PWM consumer sees stable values.

Test Plan:
1. DEPTH=4, SAMPLE_DIV=4: hold reset=0, then release → pwm_ref=16, empty=1, level=0, underrun=0.
2. Set enable=1 and write 3,7 → PRIME until level=2, then PLAY. pwm_ref=3 after 4 cycles and 7 after 8 cycles, each with a one-cycle sample_tick.
3. Continue scenario 2 with no writes → the third due pop sets underrun=1, pwm_ref stays 7, state PRIME. Assert clear_underrun and write one more sample in the same cycle → underrun drops to 0 and the state stays PRIME (level 1 < 2).
4. Write 5 samples with enable=0 → full=1 after the 4th, the 5th is dropped, level=4, pwm_ref stays 16.
5. In PLAY with level=2, drop enable to 0 mid-period → next edge pwm_ref=16, divider 0, level still 2. Re-enable → PRIME, then PLAY on the next edge.
6. In PLAY, pulse flush on the exact edge a pop is due → level=0, no sample_tick, pwm_ref unchanged, state PRIME. Assert reset=0 mid-period → all outputs take reset values immediately, without waiting for a clk edge.
